mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master memory arbiter (round robin) with an M1 burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [2:0]  m0_sel,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [2:0]  m1_sel,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [4:0]  m0_exc,
    output logic [4:0]  m1_exc,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic [2:0]  s_sel,
    output logic        s_req,
    input  logic [31:0] s_rdata,
    input  logic [4:0]  s_exc
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [4:0] c_lock_last = 5'(LOCK_MAX - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;          // 0 = M0 granted last, 1 = M1
    logic [4:0]  lock_cnt_q, lock_cnt_d;
    logic        m0_rvalid_q, m0_rvalid_d;
    logic        m1_rvalid_q, m1_rvalid_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic [4:0]  m0_exc_q, m0_exc_d;
    logic [4:0]  m1_exc_q, m1_exc_d;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_exc_any;

    assign w_exc_any = (s_exc != 5'd0);

    // Grant decision; reset forces both grants low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            case (state_q)
                ST_ARB: begin
                    if (m0_req && m1_req) begin
                        w_gnt0 = last_q;
                        w_gnt1 = ~last_q;
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
                ST_LOCK: w_gnt1 = m1_req;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_we    = 1'b0;
        s_sel   = 3'b000;
        s_req   = 1'b1;
        if (w_gnt0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_we    = m0_we;
            s_sel   = m0_sel;
            s_req   = 1'b0;
        end else if (w_gnt1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_we    = m1_we;
            s_sel   = m1_sel;
            s_req   = 1'b0;
        end
    end

    // Next state, last-grant and lock beat counter.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (w_gnt0) begin
                    last_d = 1'b0;
                end
                if (w_gnt1) begin
                    last_d = 1'b1;
                    if (m1_lock && !w_exc_any) begin
                        state_d    = ST_LOCK;
                        lock_cnt_d = 5'd1;
                    end
                end
            end
            ST_LOCK: begin
                // Leaving with last=M1 hands the next contention to M0.
                if (!m1_req || !m1_lock || w_exc_any || (lock_cnt_q == c_lock_last)) begin
                    state_d    = ST_ARB;
                    last_d     = 1'b1;
                    lock_cnt_d = 5'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 5'd1;
                end
            end
            default: begin
                state_d    = ST_ARB;
                last_d     = 1'b1;
                lock_cnt_d = 5'd0;
            end
        endcase
    end

    always_comb begin
        m0_rvalid_d = w_gnt0;
        m1_rvalid_d = w_gnt1;
        m0_rdata_d  = w_gnt0 ? s_rdata : m0_rdata_q;
        m0_exc_d    = w_gnt0 ? s_exc   : m0_exc_q;
        m1_rdata_d  = w_gnt1 ? s_rdata : m1_rdata_q;
        m1_exc_d    = w_gnt1 ? s_exc   : m1_exc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_ARB;
            last_q      <= 1'b1;
            lock_cnt_q  <= 5'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            m0_exc_q    <= 5'd0;
            m1_exc_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_exc_q    <= m0_exc_d;
            m1_exc_q    <= m1_exc_d;
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_exc    = m0_exc_q;
    assign m1_exc    = m1_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]  m0_sel, m1_sel;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [4:0]  m0_exc, m1_exc;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_we, s_req;
    logic [2:0]  s_sel;
    logic [4:0]  s_exc;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_sel(m0_sel),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_exc(m0_exc), .m1_exc(m1_exc),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_sel(s_sel), .s_req(s_req),
        .s_rdata(s_rdata), .s_exc(s_exc)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_sel = 0; m1_sel = 0; s_rdata = 0; s_exc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m0_req = 1; m1_req = 1; m1_lock = 1; m0_we = 1; m0_addr = 32'hDEAD_BEEF; m0_sel = 3'b111;
        s_rdata = 32'h5555_AAAA; s_exc = 5'd3;
        #1;
        total++;
        if ({m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata} !== {1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_comb got gnt=%b%b s_req=%b s_we=%b s_sel=%h s_addr=%h want gnt=00 s_req=1 idle bus",
                     m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr);
        end
        tick();
        total++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_exc, m1_exc} !== 76'd0) begin
            bad++;
            $display("FAIL reset_regs got rv=%b%b rd0=%h rd1=%h ex0=%h ex1=%h want all zero",
                     m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_exc, m1_exc);
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit exp0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_req = 1; m1_req = 1; m1_lock = 0; s_rdata = 32'hA000_0000 + i; s_exc = 0;
            #1;
            exp0 = (i % 2 == 0);
            total++;
            if (m0_gnt !== exp0 || m1_gnt !== ~exp0) begin
                bad++;
                $display("FAIL rr_gnt[%0d] got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, exp0, ~exp0);
            end
            tick();
            total++;
            if (m0_rvalid !== exp0 || m1_rvalid !== ~exp0 || (exp0 ? m0_rdata : m1_rdata) !== 32'hA000_0000 + i) begin
                bad++;
                $display("FAIL rr_rvalid[%0d] got rv=%b%b rd0=%h rd1=%h want m0_rv=%b data=%h",
                         i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp0, 32'hA000_0000 + i);
            end
        end
        idle_inputs();
    endtask

    task automatic test_single_load();
        do_reset();
        m0_req = 1; m0_addr = 32'h0000_0010; m0_we = 0; m0_sel = 3'b010;
        s_rdata = 32'h1234_5678; s_exc = 0;
        #1;
        total++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || s_addr !== 32'h10 || s_req !== 1'b0 || s_sel !== 3'b010) begin
            bad++;
            $display("FAIL load_comb got gnt=%b%b s_addr=%h s_req=%b s_sel=%h want gnt=10 addr=10 s_req=0 sel=2",
                     m0_gnt, m1_gnt, s_addr, s_req, s_sel);
        end
        tick();
        idle_inputs();
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678 || m0_exc !== 5'd0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL load_resp got rv=%b%b rd0=%h ex0=%h want rv=10 rd0=12345678 ex0=0",
                     m0_rvalid, m1_rvalid, m0_rdata, m0_exc);
        end
        #1;
        tick();
        total++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL load_pulse got rv0=%b rd0=%h want rv0=0 rd0 held 12345678", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_lock_burst();
        bit exp0;
        do_reset();
        // M0 first (last=M1 after reset), then the 4-beat M1 lock, then M0.
        for (int i = 0; i < 7; i++) begin
            m0_req = 1; m1_req = 1; m1_lock = 1; s_exc = 0; s_rdata = 32'hB000_0000 + i;
            #1;
            exp0 = (i == 0 || i == 5);
            total++;
            if (m0_gnt !== exp0 || m1_gnt !== ~exp0) begin
                bad++;
                $display("FAIL lock_burst[%0d] got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, exp0, ~exp0);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock_abort();
        bit exp0;
        logic [4:0] exc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exc = (i == 2) ? 5'd5 : 5'd0;
            m0_req = 1; m1_req = 1; m1_lock = 1; s_exc = exc; s_rdata = 32'hC000_0000 + i;
            #1;
            exp0 = (i == 0 || i == 3);
            total++;
            if (m0_gnt !== exp0 || m1_gnt !== ~exp0) begin
                bad++;
                $display("FAIL abort_gnt[%0d] got m0=%b m1=%b want m0=%b", i, m0_gnt, m1_gnt, exp0);
            end
            tick();
            if (i == 2) begin
                total++;
                if (m1_rvalid !== 1'b1 || m1_exc !== 5'd5 || m0_rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_exc got rv=%b%b ex1=%h want rv=01 ex1=5", m0_rvalid, m1_rvalid, m1_exc);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_idle();
        do_reset();
        m0_we = 1; m1_we = 1; m0_sel = 3'b101; m1_sel = 3'b011; m0_addr = 32'h44; m1_wdata = 32'h99;
        #1;
        total++;
        if ({m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata} !== {1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL idle_bus got gnt=%b%b s_req=%b s_we=%b s_sel=%h s_addr=%h s_wdata=%h want idle",
                     m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata);
        end
        tick();
        total++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL idle_rvalid got rv=%b%b want 00", m0_rvalid, m1_rvalid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m0_req = 1; m1_req = 1; m1_lock = 1; s_exc = 0;
            tick();
        end
        // Beat 3 of the M1 lock happens under reset.
        reset = 1'b0;
        #1;
        total++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || s_req !== 1'b1) begin
            bad++;
            $display("FAIL midlock_gnt got gnt=%b%b s_req=%b want gnt=00 s_req=1", m0_gnt, m1_gnt, s_req);
        end
        tick();
        reset = 1'b1;
        total++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midlock_rvalid got rv=%b%b want 00", m0_rvalid, m1_rvalid);
        end
        m1_lock = 0;
        #1;
        total++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL midlock_first got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_m0_no_lock();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            m0_req = 1; m1_req = 0; m1_lock = 1; s_exc = 0;
            #1;
            total++;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                bad++;
                $display("FAIL m0_nolock[%0d] got m0=%b m1=%b want m0=1 m1=0", i, m0_gnt, m1_gnt);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_exc();
        do_reset();
        m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 32'h0000_0203; m1_wdata = 32'hFEED_0001;
        m1_sel = 3'b010; s_exc = 5'd7; s_rdata = 32'h0;
        #1;
        total++;
        if (m1_gnt !== 1'b1 || s_we !== 1'b1 || s_req !== 1'b0 || s_wdata !== 32'hFEED_0001 || s_addr !== 32'h203) begin
            bad++;
            $display("FAIL store_comb got m1_gnt=%b s_we=%b s_req=%b s_wdata=%h s_addr=%h want 1 1 0 feed0001 203",
                     m1_gnt, s_we, s_req, s_wdata, s_addr);
        end
        tick();
        idle_inputs();
        total++;
        if (m1_rvalid !== 1'b1 || m1_exc !== 5'd7) begin
            bad++;
            $display("FAIL store_exc got rv1=%b ex1=%h want rv1=1 ex1=7", m1_rvalid, m1_exc);
        end
    endtask

    task automatic test_random();
        bit         locked;
        int         beats;
        bit         last_m1;
        bit         g0, g1;
        logic [72:0] exp_bus;
        logic [75:0] exp_regs;
        logic        e_rv0, e_rv1;
        logic [31:0] e_rd0, e_rd1;
        logic [4:0]  e_ex0, e_ex1;
        do_reset();
        locked = 0; beats = 0; last_m1 = 1;
        e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0; e_ex0 = 0; e_ex1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset    = ($urandom_range(0, 49) != 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 4) != 0);
            m1_lock  = ($urandom_range(0, 5) != 0);
            m0_addr  = $urandom;  m1_addr  = $urandom;
            m0_wdata = $urandom;  m1_wdata = $urandom;
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_sel   = 3'($urandom_range(0, 7));
            m1_sel   = 3'($urandom_range(0, 7));
            s_rdata  = $urandom;
            s_exc    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            #1;
            if (!reset) begin
                g0 = 0; g1 = 0;
            end else if (locked) begin
                g0 = 0; g1 = m1_req;
            end else if (m0_req && m1_req) begin
                g0 = last_m1; g1 = !last_m1;
            end else begin
                g0 = m0_req; g1 = m1_req;
            end
            if (g0)
                exp_bus = {1'b1, 1'b0, 1'b0, m0_we, m0_sel, m0_addr, m0_wdata};
            else if (g1)
                exp_bus = {1'b0, 1'b1, 1'b0, m1_we, m1_sel, m1_addr, m1_wdata};
            else
                exp_bus = {1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0};
            total++;
            if ({m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata} !== exp_bus) begin
                bad++;
                $display("FAIL rand_bus[%0d] got gnt=%b%b s_req=%b addr=%h want gnt=%b%b s_req=%b addr=%h (locked=%0d beats=%0d)",
                         cyc, m0_gnt, m1_gnt, s_req, s_addr, g0, g1, !(g0 || g1), exp_bus[63:32], locked, beats);
            end
            if (!reset) begin
                locked = 0; beats = 0; last_m1 = 1;
                e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0; e_ex0 = 0; e_ex1 = 0;
            end else begin
                e_rv0 = g0; e_rv1 = g1;
                if (g0) begin e_rd0 = s_rdata; e_ex0 = s_exc; end
                if (g1) begin e_rd1 = s_rdata; e_ex1 = s_exc; end
                if (!locked) begin
                    if (g0) last_m1 = 0;
                    if (g1) begin
                        last_m1 = 1;
                        if (m1_lock && s_exc == 0) begin locked = 1; beats = 1; end
                    end
                end else if (!m1_req) begin
                    locked = 0; last_m1 = 1;
                end else begin
                    beats++;
                    if (!m1_lock || s_exc != 0 || beats == LOCK_MAX) begin
                        locked = 0; last_m1 = 1;
                    end
                end
            end
            tick();
            exp_regs = {e_rv0, e_rd0, e_ex0, e_rv1, e_rd1, e_ex1};
            total++;
            if ({m0_rvalid, m0_rdata, m0_exc, m1_rvalid, m1_rdata, m1_exc} !== exp_regs) begin
                bad++;
                $display("FAIL rand_resp[%0d] got rv=%b%b rd0=%h rd1=%h ex=%h/%h want rv=%b%b rd0=%h rd1=%h ex=%h/%h",
                         cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_exc, m1_exc,
                         e_rv0, e_rv1, e_rd0, e_rd1, e_ex0, e_ex1);
            end
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_round_robin();
        test_single_load();
        test_lock_burst();
        test_lock_abort();
        test_idle();
        test_reset_mid_lock();
        test_m0_no_lock();
        test_store_exc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
